out_share_arbiter: RTL and testbench
====================================

Name: out_share_arbiter

Overview:
- Round-robin arbiter sharing the single 1-bit `out` net of a middle-level wrapper among NUM_REQ sub_module instances.
- Each instance requests ownership of `out`, and exactly one instance drives it at a time.
- A one-cycle turnaround gap is inserted between owners.
- The output is registered, so there is never a multi-driver conflict.

Parameters:
- NUM_REQ, 3, number of requesting instances (2..8).
- MAX_HOLD, 8, maximum ownership cycles before forced preemption when another request is pending (1..255).
- DEFAULT_OUT, 1'b0, value driven on `out` when no owner exists (idle or gap).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-instance ownership request, level.
- rel  input  NUM_REQ  per-instance release pulse; only effective for the current owner.
- din  input  NUM_REQ  per-instance data bit to be forwarded when owning.
- gnt  output  NUM_REQ  one-hot grant, registered.
- owner  output  3  binary index of current owner; valid only while busy=1.
- busy  output  1  high while any grant is active.
- out  output  1  registered shared output.
- preempt  output  1  one-cycle pulse when an owner is forcibly revoked.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, gnt=0, owner=0, busy=0, preempt=0.
  - out=DEFAULT_OUT, rr_ptr=0, hold_cnt=0.
- States: IDLE, OWN, GAP.
- IDLE:
  - If req!=0, select the first set bit searching from rr_ptr upward with wrap.
  - Next cycle: gnt=onehot(sel), owner=sel, busy=1, hold_cnt=1, state=OWN.
  - Grant latency is one cycle from a sampled request.
  - If req==0, stay in IDLE.
- OWN:
  - out <= din[owner] every cycle, one-cycle registered latency from din.
  - hold_cnt increments and saturates at MAX_HOLD.
  - Release condition: rel[owner]=1, or req[owner]=0.
  - On release: gnt=0, busy=0, rr_ptr=(owner+1) mod NUM_REQ, state=GAP.
- GAP:
  - Lasts exactly one cycle; out=DEFAULT_OUT.
  - Then arbitration runs in the same way as in IDLE: go to OWN with the new grant if any req bit is set, else go to IDLE.
  - The releasing owner may win again only if it is the sole requester.
- rel and req bits of non-owners are ignored for release purposes.
- Simultaneous events:
  - rel and the preemption condition in the same cycle are treated as a normal release; preempt stays 0.
  - req asserted during GAP is sampled in GAP and can win.
- Arithmetic and width rules:
  - rr_ptr wraps modulo NUM_REQ.
  - hold_cnt is 8 bits wide.
  - For non-power-of-two NUM_REQ, rr_ptr never takes values >= NUM_REQ.
- If reset is asserted mid-ownership, gnt drops immediately (asynchronously) and out returns to DEFAULT_OUT. There is no gap cycle after reset.
- Invariants:
  - gnt is always zero or one-hot.
  - busy == |gnt.
  - No gnt bit is high during GAP.

Optional Feature:
- Macro: OUT_SHARE_PREEMPT_EN.
- Defined:
  - When OWN, hold_cnt==MAX_HOLD, and any other req bit is set, the owner is revoked.
  - Revocation follows the same path as a release (rr_ptr advance, GAP) and pulses preempt=1 for one cycle, aligned with gnt dropping.
- Undefined:
  - The owner holds until rel or its req drops, regardless of hold_cnt.
  - preempt is tied to 0.
  - hold_cnt logic may be removed.

Test Plan:
- Reset then single requester: req=3'b010 at cycle 5 -> gnt=3'b010, owner=1, busy=1 at cycle 6. din[1] toggling 0,1,0 from cycle 6 -> out shows 0,1,0 from cycle 7. rel[1] pulse at cycle 10 -> gnt=0 at cycle 11, out=0 in GAP.
- Round-robin fairness: req=3'b111 held and each owner pulses rel 2 cycles after grant -> grant order 0,1,2,0. Exactly one GAP cycle between consecutive grants, during which gnt=000.
- Non-owner release ignored: owner=0, rel=3'b110 pulsed -> gnt stays 3'b001, out keeps following din[0].
- Preemption with OUT_SHARE_PREEMPT_EN and MAX_HOLD=4: req=3'b011 with no rel -> owner 0 held 4 cycles, then preempt=1 for one cycle, one GAP cycle, then gnt=3'b010. Same stimulus without the macro -> owner 0 keeps the grant indefinitely and preempt stays 0.
- Sole requester re-grant: req=3'b100 only, rel[2] pulse -> GAP, then gnt=3'b100 again. rr_ptr wraps to 0.
- Async reset mid-ownership: reset=0 driven between clock edges while gnt=3'b010 -> gnt=0, busy=0, out=DEFAULT_OUT before the next edge. After release with req=3'b010 still held, the grant returns one cycle after the first sampling edge.

Source files
------------

// File: rtl/out_share_arbiter.sv
// rtl/out_share_arbiter.sv - round-robin owner arbiter for a shared 1-bit output net
//
// Purpose:
//   Shares one registered 1-bit output among NUM_REQ requesters. Exactly one
//   requester owns the output at a time. A single turnaround (GAP) cycle with
//   out=DEFAULT_OUT separates consecutive owners. Arbitration is round-robin
//   starting from rr_ptr, which advances past each owner as it leaves.
//
// Optional feature macro: OUT_SHARE_PREEMPT_EN
//   When defined, an owner that has held the output for MAX_HOLD cycles while
//   another requester is waiting is revoked, and preempt pulses for one cycle.
//   When undefined, the owner holds until it releases and preempt stays 0.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   req      in   [NUM_REQ] per-requester ownership request (level)
//   rel      in   [NUM_REQ] per-requester release pulse (owner only)
//   din      in   [NUM_REQ] per-requester data bit forwarded while owning
//   gnt      out  [NUM_REQ] registered one-hot grant
//   owner    out  [3] binary index of the owner, valid while busy=1
//   busy     out  high while a grant is active
//   out      out  registered shared output
//   preempt  out  one-cycle pulse when an owner is forcibly revoked

module out_share_arbiter #(
  parameter int   NUM_REQ     = 3,
  parameter int   MAX_HOLD    = 8,
  parameter logic DEFAULT_OUT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rel,
  input  logic [NUM_REQ-1:0] din,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         owner,
  output logic               busy,
  output logic               out,
  output logic               preempt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]         state_q,    state_d;
  logic [NUM_REQ-1:0] gnt_q,      gnt_d;
  logic [2:0]         owner_q,    owner_d;
  logic               busy_q,     busy_d;
  logic               out_q,      out_d;
  logic               preempt_q,  preempt_d;
  logic [2:0]         rr_ptr_q,   rr_ptr_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;

  // Inputs widened to 8 bits so a 3-bit index is always a legal select,
  // whatever NUM_REQ is.
  logic [7:0] req_x;
  logic [7:0] rel_x;
  logic [7:0] din_x;

  assign req_x = 8'(req);
  assign rel_x = 8'(rel);
  assign din_x = 8'(din);

  // Round-robin search: first set request at or after rr_ptr, with wrap.
  logic               arb_found;
  logic [2:0]         arb_sel;
  logic [3:0]         arb_cand;
  logic [NUM_REQ-1:0] arb_onehot;

  always_comb begin
    arb_found = 1'b0;
    arb_sel   = 3'd0;
    arb_cand  = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_cand = {1'b0, rr_ptr_q} + 4'(i);
      // rr_ptr < NUM_REQ and i < NUM_REQ, so one subtraction wraps fully.
      if (arb_cand >= 4'(NUM_REQ)) begin
        arb_cand = arb_cand - 4'(NUM_REQ);
      end
      if (!arb_found && req_x[arb_cand[2:0]]) begin
        arb_found = 1'b1;
        arb_sel   = arb_cand[2:0];
      end
    end
  end

  always_comb begin
    arb_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_onehot[i] = (arb_sel == 3'(i));
    end
  end

  // Pointer position just past the current owner.
  logic [2:0] next_ptr;
  assign next_ptr = (owner_q == 3'(NUM_REQ - 1)) ? 3'd0 : owner_q + 3'd1;

  // Only the owner's own rel/req bits can end its ownership.
  logic release_c;
  assign release_c = rel_x[owner_q] || !req_x[owner_q];

  logic preempt_c;
`ifdef OUT_SHARE_PREEMPT_EN
  // gnt_q is the owner's one-hot while in OWN, so masking it leaves the
  // requests of everyone else.
  logic other_req;
  assign other_req = |(req & ~gnt_q);
  assign preempt_c = (hold_cnt_q == 8'(MAX_HOLD)) && other_req;
`else
  assign preempt_c = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    busy_d     = busy_q;
    out_d      = DEFAULT_OUT;
    preempt_d  = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      ST_OWN: begin
        if (release_c || preempt_c) begin
          state_d   = ST_GAP;
          gnt_d     = '0;
          busy_d    = 1'b0;
          rr_ptr_d  = next_ptr;
          // A voluntary release in the same cycle wins over revocation.
          preempt_d = preempt_c && !release_c;
        end else begin
          out_d = din_x[owner_q];
          if (hold_cnt_q < 8'(MAX_HOLD)) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        // IDLE and GAP arbitrate identically; the GAP cycle itself comes
        // from out/gnt being forced idle on the release edge.
        if (arb_found) begin
          state_d    = ST_OWN;
          gnt_d      = arb_onehot;
          owner_d    = arb_sel;
          busy_d     = 1'b1;
          hold_cnt_d = 8'd1;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      owner_q    <= 3'd0;
      busy_q     <= 1'b0;
      out_q      <= DEFAULT_OUT;
      preempt_q  <= 1'b0;
      rr_ptr_q   <= 3'd0;
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      out_q      <= out_d;
      preempt_q  <= preempt_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign out     = out_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_out_share_arbiter.sv
// tb/tb_out_share_arbiter.sv - self-checking bench for out_share_arbiter

module tb_out_share_arbiter;

  localparam int   N    = 3;
  localparam int   MAXH = 4;
  localparam logic DEF  = 1'b0;
`ifdef OUT_SHARE_PREEMPT_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] rel;
  logic [N-1:0] din;
  logic [N-1:0] gnt;
  logic [2:0]   owner;
  logic         busy;
  logic         out;
  logic         preempt;

  out_share_arbiter #(
    .NUM_REQ    (N),
    .MAX_HOLD   (MAXH),
    .DEFAULT_OUT(DEF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .rel    (rel),
    .din    (din),
    .gnt    (gnt),
    .owner  (owner),
    .busy   (busy),
    .out    (out),
    .preempt(preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: who owns the output (-1 = nobody), where the next
  // search starts, and how long the owner has held it.
  int m_own;
  int m_rr;
  int m_hold;
  bit m_out;
  bit m_pre;

  task automatic model_reset();
    m_own  = -1;
    m_rr   = 0;
    m_hold = 0;
    m_out  = DEF;
    m_pre  = 1'b0;
  endtask

  task automatic model_step();
    bit leave;
    bit others;
    bit force_off;
    int c;
    if (!reset) begin
      model_reset();
    end else if (m_own >= 0) begin
      leave     = rel[m_own] || !req[m_own];
      others    = (int'(req) & ~(1 << m_own)) != 0;
      force_off = PRE_EN && (m_hold >= MAXH) && others;
      if (leave || force_off) begin
        m_pre = !leave;
        m_rr  = (m_own + 1) % N;
        m_own = -1;
        m_out = DEF;
      end else begin
        m_pre = 1'b0;
        m_out = din[m_own];
        if (m_hold < MAXH) m_hold++;
      end
    end else begin
      m_pre = 1'b0;
      m_out = DEF;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (req[c]) begin
          m_own  = c;
          m_hold = 1;
          break;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      model_step();
    end
  end

  // Cycle-by-cycle comparison against the model, away from the clock edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("gnt", 32'(gnt), (m_own >= 0) ? 32'(1 << m_own) : 32'd0);
      check("busy", 32'(busy), 32'(m_own >= 0));
      check("out", 32'(out), 32'(m_out));
      check("preempt", 32'(preempt), 32'(m_pre));
      if (m_own >= 0) check("owner", 32'(owner), 32'(m_own));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  logic [N-1:0] exp_gnt [6];
  logic         exp_pre [6];
  int           rr_order [4];

  initial begin
    reset = 1'b0;
    req   = '0;
    rel   = '0;
    din   = '0;
    repeat (3) step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(out), 32'(DEF));
    check("rst_preempt", 32'(preempt), 32'd0);
    reset = 1'b1;
    step();
    check("idle_gnt", 32'(gnt), 32'd0);

    // Single requester, data forwarding, release and sole-requester re-grant.
    req = 3'b010;
    step();
    check("single_gnt", 32'(gnt), 32'b010);
    check("single_owner", 32'(owner), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    din = 3'b000;
    step();
    check("fwd0", 32'(out), 32'd0);
    din = 3'b010;
    step();
    check("fwd1", 32'(out), 32'd1);
    din = 3'b000;
    step();
    check("fwd2", 32'(out), 32'd0);
    rel = 3'b010;
    step();
    rel = 3'b000;
    check("rel_gap_gnt", 32'(gnt), 32'd0);
    check("rel_gap_busy", 32'(busy), 32'd0);
    check("rel_gap_out", 32'(out), 32'(DEF));
    step();
    check("regrant1", 32'(gnt), 32'b010);
    req = 3'b100;
    step();
    check("reqdrop_gap", 32'(gnt), 32'd0);
    step();
    check("grant2", 32'(gnt), 32'b100);
    rel = 3'b100;
    step();
    rel = 3'b000;
    check("rel2_gap", 32'(gnt), 32'd0);
    step();
    check("regrant2", 32'(gnt), 32'b100);
    req = 3'b000;
    step();
    step();
    check("back_idle", 32'(busy), 32'd0);

    // Round-robin fairness with all three requesting.
    rr_order = '{0, 1, 2, 0};
    do_reset();
    req = 3'b111;
    step();
    for (int k = 0; k < 4; k++) begin
      check("rr_owner", 32'(owner), 32'(rr_order[k]));
      check("rr_gnt", 32'(gnt), 32'(1 << rr_order[k]));
      step();
      rel = 3'(1 << rr_order[k]);
      step();
      rel = 3'b000;
      check("rr_gap", 32'(gnt), 32'd0);
      step();
    end
    req = 3'b000;
    step();
    step();

    // Release pulses from non-owners are ignored.
    do_reset();
    req = 3'b011;
    step();
    check("nonown_gnt0", 32'(gnt), 32'b001);
    rel = 3'b110;
    din = 3'b001;
    step();
    rel = 3'b000;
    check("nonown_gnt1", 32'(gnt), 32'b001);
    check("nonown_out1", 32'(out), 32'd1);
    din = 3'b000;
    step();
    check("nonown_gnt2", 32'(gnt), 32'b001);
    check("nonown_out2", 32'(out), 32'd0);
    rel = 3'b001;
    step();
    rel = 3'b000;
    req = 3'b000;
    check("nonown_rel", 32'(gnt), 32'd0);
    step();

    // Hold limit behaviour with two competing requesters and no releases.
    if (PRE_EN) begin
      exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010};
      exp_pre = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    end else begin
      exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
      exp_pre = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end
    do_reset();
    req = 3'b011;
    for (int k = 0; k < 6; k++) begin
      step();
      check("hold_gnt", 32'(gnt), 32'(exp_gnt[k]));
      check("hold_pre", 32'(preempt), 32'(exp_pre[k]));
    end
    req = 3'b000;
    step();
    step();

    // Asynchronous reset in the middle of an ownership.
    do_reset();
    req = 3'b010;
    step();
    check("async_pre_gnt", 32'(gnt), 32'b010);
    din = 3'b010;
    step();
    check("async_pre_out", 32'(out), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_out", 32'(out), 32'(DEF));
    step();
    reset = 1'b1;
    step();
    check("async_regrant", 32'(gnt), 32'b010);
    req = 3'b000;
    din = 3'b000;
    step();
    step();

    // Randomised traffic, including occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 299) != 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
        rel[b] = ($urandom_range(0, 9) == 0);
      end
      din = 3'($urandom);
      step();
    end
    reset = 1'b1;
    req   = '0;
    rel   = '0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
